// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling engine: mode encodings, FSM states,
// accumulator sizing and signed saturation.
package pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A KxK window sum grows by at most 2*KDIM_W bits over the element width.
    function automatic int acc_width(input int data_w, input int kdim_w);
        return data_w + 2 * kdim_w;
    endfunction

    localparam int ACC_W_DEFAULT = acc_width(16, 3);

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/pool_lane_acc.sv
// One pooling lane: loads on the first beat of a window, then folds in later
// beats as a signed max or a signed sum; the result reflects the current beat.
module pool_lane_acc
    import pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int KDIM_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [4:0]        avg_shift,
    input  logic              load,
    input  logic              update,
    input  logic [DATA_W-1:0] elem,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W = acc_width(DATA_W, KDIM_W);

    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] elem_ext;
    logic signed [ACC_W-1:0] shifted;
    logic signed [63:0]      wide;
    logic signed [63:0]      clamped;

    assign elem_ext = ACC_W'(signed'(elem));

    always_comb begin
        acc_next = acc_reg;
        if (load) begin
            acc_next = elem_ext;
        end else if (update) begin
            if (mode == POOL_AVG) begin
                acc_next = acc_reg + elem_ext;
            end else begin
                acc_next = (elem_ext > acc_reg) ? elem_ext : acc_reg;
            end
        end
    end

    // The output path sees this beat's contribution, so the top can register
    // the result on the same handshake that completes the window.
    assign shifted = acc_next >>> avg_shift;
    assign wide    = 64'(shifted);
    assign clamped = saturate(wide, DATA_W);
    assign result  = (mode == POOL_AVG) ? clamped[DATA_W-1:0] : acc_next[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/pool_engine.sv
// Pooling engine: walks kernel/window/channel order over COLS lanes and emits
// one pooled value per lane per window through a single output register.
module pool_engine
    import pool_pkg::*;
#(
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int KDIM_W = 3,
    parameter int POS_W  = 4,
    parameter int CH_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_mode,
    input  logic [KDIM_W-1:0]      cfg_kernel_dim,
    input  logic [KDIM_W-1:0]      cfg_stride,
    input  logic [POS_W-1:0]       cfg_last_pos,
    input  logic [CH_W-1:0]        cfg_channels,
    input  logic [4:0]             cfg_avg_shift,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COLS*DATA_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*DATA_W-1:0] out_data,
    output logic [POS_W-1:0]       out_pos,
    output logic [CH_W-1:0]        out_channel,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    state_t state_reg;
    state_t state_next;

    logic                   mode_reg;
    logic [KDIM_W-1:0]      k_reg;
    logic [KDIM_W-1:0]      stride_reg;
    logic [POS_W-1:0]       last_pos_reg;
    logic [CH_W-1:0]        channels_reg;
    logic [4:0]             shift_reg;
    logic [KDIM_W-1:0]      kx_reg;
    logic [KDIM_W-1:0]      ky_reg;
    logic [POS_W-1:0]       pos_reg;
    logic [CH_W-1:0]        ch_reg;
    logic [COLS*DATA_W-1:0] lane_result;

    logic cfg_ok;
    logic beat;
    logic first_beat;
    logic kx_end;
    logic ky_end;
    logic win_end;
    logic pos_end;
    logic ch_end;
    logic run_end;
    logic out_hs;

    assign cfg_ok     = (cfg_kernel_dim != '0) && (cfg_stride != '0) && (cfg_channels != '0);
    assign in_ready   = (state_reg == ST_RUN) && (!out_valid || out_ready);
    assign beat       = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    assign first_beat = (kx_reg == '0) && (ky_reg == '0);
    assign kx_end     = (kx_reg == k_reg - KDIM_W'(1));
    assign ky_end     = (ky_reg == k_reg - KDIM_W'(1));
    assign win_end    = kx_end && ky_end;
    assign pos_end    = (pos_reg >= last_pos_reg);
    assign ch_end     = (ch_reg == channels_reg - CH_W'(1));
    assign run_end    = beat && win_end && pos_end && ch_end;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cfg_start && cfg_ok) state_next = ST_RUN;
            ST_RUN:   if (run_end) state_next = ST_DRAIN;
            ST_DRAIN: if (out_hs) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= POOL_MAX;
            k_reg        <= '0;
            stride_reg   <= '0;
            last_pos_reg <= '0;
            channels_reg <= '0;
            shift_reg    <= '0;
            kx_reg       <= '0;
            ky_reg       <= '0;
            pos_reg      <= '0;
            ch_reg       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_pos      <= '0;
            out_channel  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done      <= 1'b0;

            if (state_reg == ST_IDLE && cfg_start) begin
                if (cfg_ok) begin
                    mode_reg     <= cfg_mode;
                    k_reg        <= cfg_kernel_dim;
                    stride_reg   <= cfg_stride;
                    last_pos_reg <= cfg_last_pos;
                    channels_reg <= cfg_channels;
                    shift_reg    <= cfg_avg_shift;
                    kx_reg       <= '0;
                    ky_reg       <= '0;
                    pos_reg      <= '0;
                    ch_reg       <= '0;
                    busy         <= 1'b1;
                    cfg_err      <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            if (beat) begin
                if (!kx_end) begin
                    kx_reg <= kx_reg + KDIM_W'(1);
                end else begin
                    kx_reg <= '0;
                    if (!ky_end) begin
                        ky_reg <= ky_reg + KDIM_W'(1);
                    end else begin
                        ky_reg <= '0;
                        if (pos_end) begin
                            pos_reg <= '0;
                            ch_reg  <= ch_reg + CH_W'(1);
                        end else begin
                            pos_reg <= pos_reg + POS_W'(stride_reg);
                        end
                    end
                end
            end

            // Reload takes priority so a window completing alongside the
            // previous output's handshake keeps out_valid high.
            if (beat && win_end) begin
                out_valid   <= 1'b1;
                out_data    <= lane_result;
                out_pos     <= pos_reg;
                out_channel <= ch_reg;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end

            if (state_reg == ST_DRAIN && out_hs) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
        pool_lane_acc #(
            .DATA_W (DATA_W),
            .KDIM_W (KDIM_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .mode      (mode_reg),
            .avg_shift (shift_reg),
            .load      (beat && first_beat),
            .update    (beat && !first_beat),
            .elem      (in_data[gi*DATA_W +: DATA_W]),
            .result    (lane_result[gi*DATA_W +: DATA_W])
        );
    end

endmodule
